// File: rtl/snn_sram_pkg.sv
// snn_sram_pkg: shared SRAM geometry defaults and access controller state encoding.
package snn_sram_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_SRAM_DEPTH = 256;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: in-order read response buffer with occupancy count.
module sram_rsp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [CW-1:0]    count
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic pop_ok;

    always_comb begin
        valid = count != '0;
        pop_ok = pop && valid;
        dout = mem[rptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr == LAST ? '0 : wptr + 1'b1;
            if (pop_ok) rptr <= rptr == LAST ? '0 : rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

endmodule

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: zero-fills an SRAM after reset or on request, then arbitrates
// read/write requests with credit-limited, in-order read responses.
module sram_access_ctrl
    import snn_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SRAM_DEPTH = DEF_SRAM_DEPTH,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  start_clear,
    output logic                  init_done,
    output logic                  busy,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(SRAM_DEPTH - 1);

    state_t state;
    logic [ADDR_WIDTH:0] cnt;
    logic [CW-1:0] count;
    logic inflight, acc, clr, pop;

    // a read issued last cycle already owns a FIFO slot, so it counts as a credit
    always_comb begin
        clr = state == CLEAR;
        req_ready = state == RUN && !start_clear &&
                    ((CW + 1)'(count) + (CW + 1)'(inflight) < (CW + 1)'(RSP_DEPTH));
        acc = req_valid && req_ready;
        sram_cs = clr || acc;
        sram_we = clr || (acc && req_we);
        sram_a = clr ? cnt[ADDR_WIDTH-1:0] : acc ? req_addr : '0;
        sram_d = acc ? req_wdata : '0;
        pop = rsp_valid && rsp_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            cnt <= '0;
            inflight <= 1'b0;
            init_done <= 1'b0;
            busy <= 1'b1;
        end else begin
            inflight <= acc && !req_we;
            case (state)
                BOOT: state <= CLEAR;
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= RUN;
                        cnt <= '0;
                        busy <= 1'b0;
                        init_done <= 1'b1;
                    end
                end
                RUN: if (start_clear) begin
                    state <= DRAIN;
                    busy <= 1'b1;
                end
                DRAIN: if (!inflight) state <= CLEAR;
                default: state <= BOOT;
            endcase
        end
    end

    sram_rsp_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RSP_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .din   (sram_q),
        .pop   (pop),
        .dout  (rsp_data),
        .valid (rsp_valid),
        .count (count)
    );

endmodule
